// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge_pkg: shared types and constants for the SPI register bridge
package spi_reg_bridge_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  localparam int CMD_BITS = 8;
  localparam logic [3:0] STATUS_ADDR = 4'hF;
  localparam int W_BIT = 7;
  localparam logic SCLK_RST = 1'b0;
  localparam logic CS_N_RST = 1'b1;
  localparam logic MOSI_RST = 1'b0;
endpackage

// File: rtl/spi_reg_bridge_sync_edge.sv
// sync_edge: multi-flop synchroniser with rise/fall pulse detection
// Ports: clk/rst (async active-high), d_i async input, lvl_o synchronised level,
// rise_o/fall_o one-clk pulses on level change (detected against a registered copy).
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= lvl_o;
    end
  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o = lvl_o & ~prev_q;
  assign fall_o = ~lvl_o & prev_q;
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave turning 16-bit frames into register bus reads/writes
// Ports: clk, rst (async active-high); sclk/cs_n/mosi SPI inputs, miso/miso_oe SPI output;
// addr/wdata/we/rdata register bus; busy high while a frame is in progress.
// Option: SPI_REG_BRIDGE_STATUS_EN maps a status byte onto reads of STATUS_ADDR.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [3:0] addr,
  output logic [7:0] wdata,
  output logic       we,
  input  logic [7:0] rdata,
  output logic       busy
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl;
  logic [1:0] mosi_edge_unused;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, tx_q, tx_d, wdata_q, wdata_d, rx, rd_val;
  logic [3:0] addr_q, addr_d;
  logic miso_q, miso_d, we_q, we_d, w_q, w_d, load_q, load_d;
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_RST)) u_sclk (
    .clk(clk), .rst(rst), .d_i(sclk), .lvl_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_RST)) u_cs (
    .clk(clk), .rst(rst), .d_i(cs_n), .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_RST)) u_mosi (
    .clk(clk), .rst(rst), .d_i(mosi), .lvl_o(mosi_lvl), .rise_o(mosi_edge_unused[0]), .fall_o(mosi_edge_unused[1])
  );
  assign rx = {sh_q[6:0], mosi_lvl};
`ifdef SPI_REG_BRIDGE_STATUS_EN
  logic [5:0] fc_q;
  logic ab_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fc_q <= '0;
      ab_q <= 1'b0;
    end else if (state_q == DATA && state_d == DONE) begin
      fc_q <= fc_q + 6'd1;
      ab_q <= 1'b0;
    end else if ((state_q == CMD || state_q == DATA) && cs_rise) begin
      ab_q <= 1'b1;
    end
  assign rd_val = (addr_q == STATUS_ADDR) ? {fc_q, ab_q, 1'b1} : rdata;
`else
  assign rd_val = rdata;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    miso_d  = miso_q;
    w_d     = w_q;
    we_d    = 1'b0;
    load_d  = 1'b0;
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d = CMD;
        cnt_d   = '0;
      end
    end else if (state_q == DONE) begin
      if (sclk_fall) miso_d = 1'b0;
    end else begin
      if (sclk_rise) begin
        sh_d  = rx;
        cnt_d = cnt_q + 1'b1;
        if (state_q == CMD && cnt_q == CW'(CMD_BITS - 1)) begin
          state_d = DATA;
          addr_d  = rx[3:0];
          w_d     = rx[W_BIT];
          load_d  = 1'b1;
        end
        if (state_q == DATA && cnt_q == CW'(FRAME_BITS - 1)) begin
          state_d = DONE;
          wdata_d = w_q ? rx : wdata_q;
          we_d    = w_q;
        end
      end
      if (sclk_fall) begin
        miso_d = (state_q == DATA) ? tx_q[7] : 1'b0;
        tx_d   = (state_q == DATA) ? {tx_q[6:0], 1'b0} : tx_q;
      end
      // rdata is valid one clk after addr moves; write frames shift out zeros
      if (load_q) tx_d = w_q ? 8'h00 : rd_val;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      miso_q  <= 1'b0;
      we_q    <= 1'b0;
      w_q     <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      miso_q  <= miso_d;
      we_q    <= we_d;
      w_q     <= w_d;
      load_q  <= load_d;
    end
  assign miso    = miso_q;
  assign miso_oe = ~cs_lvl;
  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign we      = we_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: scoreboard bench driving SPI frames into spi_reg_bridge
module tb_spi_reg_bridge;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, we, busy;
  logic [3:0] addr;
  logic [7:0] wdata, rdata;
  logic [7:0] regs [16];
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t exp_wr[$];
  logic [7:0] exp_rd[$];
  wr_t e;
  logic we_prev = 1'b0;
  logic [7:0] rx;
  logic stray;
  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .addr(addr), .wdata(wdata), .we(we), .rdata(rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  assign rdata = regs[addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (we) begin
      if (exp_wr.size() == 0) check("we_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_wr.pop_front();
        check("we_addr", {28'd0, addr}, {28'd0, e.a});
        check("we_data", {24'd0, wdata}, {24'd0, e.d});
      end
      check("we_width", {31'd0, we_prev}, 32'd0);
      regs[addr] = wdata;
    end
    we_prev = we;
  end
  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                           input bit hold, output logic [7:0] rxb, output logic st);
    logic [15:0] f;
    f = {cmd, data};
    rxb = 8'h00;
    st = 1'b0;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? f[15-i] : 1'b0;
      repeat (6) @(negedge clk);
      if (i == 0) check("miso_oe_on", {31'd0, miso_oe}, 32'd1);
      if (i >= 8 && i < 16) rxb = {rxb[6:0], miso};
      else st = st | miso;
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
    end
    if (!hold) begin
      repeat (6) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      check("miso_oe_off", {31'd0, miso_oe}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
    end
  endtask
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int nbits);
    exp_wr.push_back('{a, d});
    spi_frame({4'h8, a}, d, nbits, 1'b0, rx, stray);
    check("miso_quiet", {31'd0, stray}, 32'd0);
  endtask
  task automatic do_read(input logic [3:0] a, input logic [7:0] expv);
    exp_rd.push_back(expv);
    spi_frame({4'h0, a}, 8'h00, 16, 1'b0, rx, stray);
    check("rd_data", {24'd0, rx}, {24'd0, exp_rd.pop_front()});
    check("miso_quiet", {31'd0, stray}, 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outs", {16'd0, miso, miso_oe, addr, wdata, we, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    do_write(4'h1, 8'hA5, 16);
    do_write(4'h2, 8'h3C, 16);
    do_read(4'h2, 8'h3C);
    do_read(4'h1, 8'hA5);
    spi_frame(8'h83, 8'hFF, 12, 1'b0, rx, stray);
    check("abort_addr", {28'd0, addr}, 32'd3);
    do_write(4'h5, 8'h5A, 16);
    do_read(4'h5, 8'h5A);
    do_write(4'h4, 8'h11, 20);
    do_read(4'h4, 8'h11);
    spi_frame(8'h8E, 8'h77, 5, 1'b1, rx, stray);
    check("busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {16'd0, miso, miso_oe, addr, wdata, we, busy}, 32'd0);
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_after_rst", {31'd0, busy}, 32'd0);
    do_write(4'h6, 8'h11, 16);
    do_write(4'h7, 8'h22, 16);
    do_write(4'h8, 8'h33, 16);
    spi_frame(8'h89, 8'h00, 6, 1'b0, rx, stray);
`ifdef SPI_REG_BRIDGE_STATUS_EN
    do_read(4'hF, 8'h0F);
`else
    do_read(4'hF, 8'h00);
`endif
    do_read(4'h7, 8'h22);
    check("wr_queue_empty", exp_wr.size(), 32'd0);
    check("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

SPI slave bridge that turns framed serial commands from an off-chip host into single-cycle register writes and reads on the `gpio_reg` bus port (`addr`/`wdata`/`we`/`rdata`). It sits directly upstream of `gpio_reg` in the TinyTapeout top and replaces the hard-wired `ui_in[3:0]` address path with a real bus master. It is clocked only by `clk`. It synchronises and oversamples the SPI pins, so `clk` must be much faster than `sclk`.

## Interface
- `FRAME_BITS`, 16: bits per complete frame (8-bit command, then 8-bit data).
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `cs_n` and `mosi`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to `clk`.
- `cs_n`  in  1  SPI chip select, active low; asynchronous.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first.
- `miso_oe`  out  1  output enable for `miso`; maps to a `uio_oe` bit.
- `addr`  out  4  register address to `gpio_reg`.
- `wdata`  out  8  write data to `gpio_reg`.
- `we`  out  1  write strobe, one `clk` wide.
- `rdata`  in  8  read data from `gpio_reg`; combinational from `addr`.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Command byte: bit7 = W (1 = write, 0 = read); bits6:4 reserved and ignored; bits3:0 = register address.
- Data byte:
  - Write frame: the byte is the write data.
  - Read frame: the byte shifted in on `mosi` is ignored, and `miso` carries the register contents.
- `mosi` is sampled on each synchronised rising edge of `sclk`.
- `miso` is updated on each synchronised falling edge of `sclk`.
- FSM states:
  - IDLE → CMD when `cs_n` falls.
  - CMD → DATA after 8 rising edges.
  - DATA → DONE after 16 rising edges.
  - DONE → IDLE when `cs_n` rises.
- In any state other than IDLE, a rising `cs_n` forces the FSM to IDLE.
- At the 8th rising edge, `addr` is loaded from the command bits3:0, for both reads and writes.
- Read frames: one `clk` after `addr` updates, `rdata` is captured into the MISO shift register. The next `sclk` falling edge drives `rdata[7]` on `miso`.
- Write frames: at the 16th rising edge, `wdata` is loaded and `we` pulses for exactly one `clk`.
- `addr` and `wdata` hold their values between frames.
- Abort: if `cs_n` rises before the 16th edge, there is no `we` pulse, the bit counter clears, and `addr` keeps the value it was last given.
- Extra edges: rising edges after the 16th (in DONE) are ignored and `miso` holds 0.
- `miso_oe` is 1 whenever the synchronised `cs_n` is low, and 0 otherwise.
- `miso` outputs 0 during the command byte.
- Reset: async `rst` sets the FSM to IDLE and the bit counter to 0. All outputs reset to 0: `miso`, `miso_oe`, `addr`, `wdata`, `we`, `busy`. The synchroniser flops also reset: `sclk`/`mosi` to 0, `cs_n` to 1.
- Reset mid-frame: the partial frame is discarded, and the bridge waits for a fresh `cs_n` falling edge.

## Timing
- Pin-to-edge-detect latency is `SYNC_STAGES`+1 `clk` cycles (3 with the default of 2).
- Requirements on the host:
  - `sclk` high and low phases are each ≥ 4 `clk` periods.
  - `cs_n` setup before the first `sclk` rise is ≥ 4 `clk`.
  - `cs_n` hold after the last `sclk` fall is ≥ 4 `clk`.
- `we` asserts 3 `clk` after the raw 16th `sclk` rise. It never overlaps a state change to IDLE caused by the same frame.
- `rdata` must be stable one `clk` after `addr` changes. This is guaranteed, because `gpio_reg` reads combinationally.
- Back-to-back frames need `cs_n` high for ≥ 4 `clk` between them.

## Configuration
- `SPI_REG_BRIDGE_STATUS_EN` defined:
  - Reads of address 4'hF return a status byte instead of `rdata`: {frame_count[5:0], last_abort, 1'b1}.
  - frame_count is a 6-bit wrapping count of completed frames.
  - last_abort is 1 if the previous frame was aborted.
  - Writes to 4'hF still drive `we`.
- `SPI_REG_BRIDGE_STATUS_EN` undefined: 4'hF is an ordinary address and the status logic is absent.

## Structure
- `spi_reg_bridge_pkg` holds:
  - the state enum (IDLE, CMD, DATA, DONE);
  - `CMD_BITS`=8;
  - `STATUS_ADDR`=4'hF;
  - `W_BIT`=7;
  - the reset values of the synchroniser flops.
- Sub-module `sync_edge`: a `SYNC_STAGES` flop synchroniser plus a registered rise/fall pulse detector, with a reset value parameter. It is instantiated three times, for `sclk`, `cs_n` and `mosi`. The `mosi` instance uses the level output only.

## Test plan
- Write: frame 0x81,0xA5 → `we` high for exactly 1 `clk` with `addr`=1 and `wdata`=0xA5; `gpio_out` reads 0xA5 afterwards.
- Read: preload register 2 = 0x3C, send frame 0x02,0x00 → 0x3C appears on `miso` MSB-first during the data byte; `we` stays 0.
- Abort: raise `cs_n` after 12 bits of frame 0x83,0xFF → no `we`, `busy` falls, and the next full write succeeds normally.
- Reset mid-frame: assert `rst` after 5 bits → all outputs are 0 at once, with no spurious `we` after `rst` releases.
- Overlong frame: send 20 bits starting 0x84,0x11 → a single `we` with `wdata`=0x11; the extra bits are ignored.
- With `SPI_REG_BRIDGE_STATUS_EN`: after 3 completed frames and 1 aborted frame, a read of 0x0F returns 0x0F (count=3, last_abort=1, bit0=1).
